// File: rtl/mollusc_mem_pkg.sv
// Shared types and defaults for the mollusc memory arbiter.
// Holds the FSM state and owner encodings plus the starvation-limit default.
package mollusc_mem_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int DEF_STARVE_MAX = 4;

    // Counter width able to hold 0..max inclusive.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requests.
// Data wins unless MEM_ARB_FAIRNESS_EN is defined and fetch has waited STARVE_MAX grants.
module mem_arb_pick
    import mollusc_mem_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                                i_window,
    input  logic                                i_if_req,
    input  logic                                i_d_req,
    input  logic [cnt_width(STARVE_MAX)-1:0]    i_starve_cnt,
    output logic                                o_if_gnt,
    output logic                                o_d_gnt
);

    localparam int CNT_W = cnt_width(STARVE_MAX);

    logic w_if_first;

`ifdef MEM_ARB_FAIRNESS_EN
    assign w_if_first = (i_starve_cnt == CNT_W'(STARVE_MAX));
`else
    logic w_unused_cnt;
    assign w_unused_cnt = ^i_starve_cnt;
    assign w_if_first   = 1'b0;
`endif

    assign o_d_gnt  = i_window && i_d_req && !(i_if_req && w_if_first);
    assign o_if_gnt = i_window && i_if_req && !o_d_gnt;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the data path.
// Define MEM_ARB_FAIRNESS_EN to compile in the fetch anti-starvation counter.
module mem_arbiter
    import mollusc_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_write,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_write,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int CNT_W = cnt_width(STARVE_MAX);

    state_t           r_state;
    owner_t           r_owner;
    logic             w_ack;
    logic             w_window;
    logic             w_accept;
    logic [CNT_W-1:0] w_starve_cnt;

    assign w_ack    = (r_state == ST_BUSY) && m_ack;
    assign w_window = rst_n && ((r_state == ST_IDLE) || w_ack);
    assign w_accept = if_gnt || d_gnt;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .i_window     (w_window),
        .i_if_req     (if_req),
        .i_d_req      (d_req),
        .i_starve_cnt (w_starve_cnt),
        .o_if_gnt     (if_gnt),
        .o_d_gnt      (d_gnt)
    );

`ifdef MEM_ARB_FAIRNESS_EN
    logic [CNT_W-1:0] r_starve_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            r_starve_cnt <= '0;
        end else if (d_gnt && (r_starve_cnt != CNT_W'(STARVE_MAX))) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

    assign w_starve_cnt = r_starve_cnt;
`else
    assign w_starve_cnt = '0;
`endif

    // A grant in the ack cycle reloads the port directly, so m_req never drops between transactions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_owner   <= OWN_IF;
            m_req     <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_write   <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
        end else begin
            if (w_accept) begin
                r_state <= ST_BUSY;
                r_owner <= d_gnt ? OWN_D : OWN_IF;
                m_req   <= 1'b1;
                m_addr  <= d_gnt ? d_addr : if_addr;
                m_wdata <= d_gnt ? d_wdata : '0;
                m_write <= d_gnt && d_write;
            end else if (w_ack) begin
                r_state <= ST_IDLE;
                m_req   <= 1'b0;
            end
            if_rvalid <= w_ack && (r_owner == OWN_IF);
            d_rvalid  <= w_ack && (r_owner == OWN_D);
            if (w_ack && (r_owner == OWN_IF)) begin
                if_rdata <= m_rdata;
            end
            if (w_ack && (r_owner == OWN_D)) begin
                d_rdata <= m_rdata;
            end
        end
    end

`ifndef SYNTHESIS
    a_ack_idle : assert property (@(posedge clk) disable iff (!rst_n)
        m_ack |-> (r_state == ST_BUSY))
        else $error("m_ack received while idle; ignored");
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions queued per owner at ack time.
// Starvation expectations follow MEM_ARB_FAIRNESS_EN.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_write;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          m_req;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_write;
    logic          m_ack;
    logic [DW-1:0] m_rdata;

    typedef struct {
        bit            chk;
        logic [DW-1:0] data;
    } exp_t;

    exp_t if_q[$];
    exp_t d_q[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_write   (d_write),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .m_req     (m_req),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_write   (m_write),
        .m_ack     (m_ack),
        .m_rdata   (m_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input bit is_if, input bit chk, input logic [DW-1:0] data);
        exp_t e;
        e.chk  = chk;
        e.data = data;
        if (is_if) if_q.push_back(e);
        else       d_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Expected fetch win in the k-th cycle of continuous contention.
    function automatic bit exp_if_win(input int k);
`ifdef MEM_ARB_FAIRNESS_EN
        return (k % (SM + 1)) == SM;
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && if_rvalid === 1'b1) begin
            if (if_q.size() == 0) check("if_rvalid_unexpected", 1, 0);
            else begin
                e = if_q.pop_front();
                if (e.chk) check("if_rdata", if_rdata, e.data);
            end
        end
        if (rst_n === 1'b1 && d_rvalid === 1'b1) begin
            if (d_q.size() == 0) check("d_rvalid_unexpected", 1, 0);
            else begin
                e = d_q.pop_front();
                if (e.chk) check("d_rdata", d_rdata, e.data);
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        if_req  = 1'b1;
        if_addr = '0;
        d_req   = 1'b1;
        d_addr  = '0;
        d_wdata = '0;
        d_write = 1'b0;
        m_ack   = 1'b0;
        m_rdata = '0;

        // reset state and gnt suppression
        tick(); tick();
        smp();
        check("rst_if_gnt", if_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        check("rst_m_req", m_req, 0);
        check("rst_m_write", m_write, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_rvalid", {if_rvalid, d_rvalid}, 0);
        check("rst_rdata", {if_rdata, d_rdata}, 0);
        tick();
        if_req = 1'b0;
        d_req  = 1'b0;
        rst_n  = 1'b1;

        // single load
        tick();
        d_req = 1'b1; d_addr = 32'h100; d_write = 1'b0;
        smp();
        check("ld_d_gnt", d_gnt, 1);
        check("ld_if_gnt", if_gnt, 0);
        tick();
        d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
        push(0, 1, 32'hDEADBEEF);
        smp();
        check("ld_m_req", m_req, 1);
        check("ld_m_addr", m_addr, 32'h100);
        check("ld_m_write", m_write, 0);
        tick();
        m_ack = 1'b0;
        smp();
        check("ld_d_rvalid", d_rvalid, 1);
        check("ld_m_req_drop", m_req, 0);

        // simultaneous requests: data store first, fetch granted in the ack cycle
        tick();
        if_req = 1'b1; if_addr = 32'h0;
        d_req = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678; d_write = 1'b1;
        smp();
        check("sim_d_gnt", d_gnt, 1);
        check("sim_if_gnt0", if_gnt, 0);
        tick();
        d_req = 1'b0;
        smp();
        check("sim_m_write", m_write, 1);
        check("sim_m_wdata", m_wdata, 32'h12345678);
        check("sim_m_addr", m_addr, 32'h40);
        check("sim_if_gnt_busy", if_gnt, 0);
        tick();
        m_ack = 1'b1; m_rdata = '0;
        push(0, 0, '0);
        smp();
        check("sim_if_gnt_ack", if_gnt, 1);
        tick();
        if_req = 1'b0; m_rdata = 32'hCAFE0001;
        push(1, 1, 32'hCAFE0001);
        smp();
        check("sim_m_req_held", m_req, 1);
        check("sim_m_addr_if", m_addr, 32'h0);
        check("sim_m_write_if", m_write, 0);
        tick();
        m_ack = 1'b0;
        smp();
        check("sim_m_req_drop", m_req, 0);

        // continuous contention with an ack every busy cycle
        tick();
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_addr = 32'h300; d_write = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                m_ack   = 1'b1;
                m_rdata = 32'hA000 + i;
                push(exp_if_win(i - 1), 1, 32'hA000 + i);
            end
            smp();
            check("stv_if_gnt", if_gnt, exp_if_win(i));
            check("stv_d_gnt", d_gnt, !exp_if_win(i));
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;
        m_ack = 1'b1; m_rdata = 32'hA00A;
        push(exp_if_win(9), 1, 32'hA00A);
        smp();
        check("stv_end_gnt", {if_gnt, d_gnt}, 0);
        tick();
        m_ack = 1'b0;
        smp();
        check("stv_m_req_drop", m_req, 0);

        // reset mid-transaction; the ack arriving with reset is discarded
        tick();
        d_req = 1'b1; d_addr = 32'h500; d_write = 1'b0;
        smp();
        check("rm_d_gnt", d_gnt, 1);
        tick();
        rst_n = 1'b0; m_ack = 1'b1; m_rdata = 32'hBAD;
        smp();
        check("rm_m_req_before", m_req, 1);
        check("rm_gnt_in_reset", d_gnt, 0);
        tick();
        rst_n = 1'b1; m_ack = 1'b0; d_req = 1'b0;
        smp();
        check("rm_m_req_after", m_req, 0);
        check("rm_rvalid", {if_rvalid, d_rvalid}, 0);
        tick();
        d_req = 1'b1; d_addr = 32'h510;
        smp();
        check("rm_idle_gnt", d_gnt, 1);
        tick();
        d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h51051;
        push(0, 1, 32'h51051);
        smp();
        check("rm_m_addr", m_addr, 32'h510);
        tick();
        m_ack = 1'b0;
        smp();
        check("rm_d_rvalid", d_rvalid, 1);

        // wait states: fetch arrives while busy and is granted only in the ack cycle
        tick();
        d_req = 1'b1; d_addr = 32'h600; d_wdata = 32'h55; d_write = 1'b1;
        smp();
        check("ws_d_gnt", d_gnt, 1);
        tick();
        d_req = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (j == 1) begin
                if_req = 1'b1; if_addr = 32'h700;
            end
            smp();
            check("ws_m_req", m_req, 1);
            check("ws_m_addr", m_addr, 32'h600);
            check("ws_m_wdata", m_wdata, 32'h55);
            check("ws_m_write", m_write, 1);
            check("ws_if_gnt_wait", if_gnt, 0);
            tick();
        end
        m_ack = 1'b1; m_rdata = '0;
        push(0, 0, '0);
        smp();
        check("ws_if_gnt_ack", if_gnt, 1);
        tick();
        if_req = 1'b0; m_ack = 1'b0;
        smp();
        check("ws_m_addr_if", m_addr, 32'h700);
        check("ws_m_req_if", m_req, 1);
        tick();
        m_ack = 1'b1; m_rdata = 32'h77;
        push(1, 1, 32'h77);
        tick();
        m_ack = 1'b0;
        smp();
        check("ws_m_req_drop", m_req, 0);
        tick();
        smp();

        check("if_q_left", if_q.size(), 0);
        check("d_q_left", d_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single memory port between instruction fetch and the execute stage's data path (the `is_mem` / `mem_addr` / `mem_val` / `mem_write` outputs). Sits between the pipeline stages and memory and issues one transaction at a time. Routes each completion back to its owner. Data requests win by default, with an optional anti-starvation guarantee for fetch.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 4, consecutive data grants allowed while fetch waits (fairness build only)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `if_req`  in  1  fetch read request; held until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  combinational; fetch request accepted this cycle
- `if_rvalid`  out  1  registered one-cycle pulse; `if_rdata` valid
- `if_rdata`  out  DATA_W  fetch read data
- `d_req`  in  1  data request; held until `d_gnt`
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_write`  in  1  1 = store, 0 = load
- `d_gnt`  out  1  combinational; data request accepted this cycle
- `d_rvalid`  out  1  registered pulse; load data valid or store complete
- `d_rdata`  out  DATA_W  load data (X on store completion)
- `m_req`  out  1  registered; transaction outstanding
- `m_addr`  out  ADDR_W  registered
- `m_wdata`  out  DATA_W  registered
- `m_write`  out  1  registered
- `m_ack`  in  1  memory completes current transaction
- `m_rdata`  in  DATA_W  read data, valid with `m_ack`

## Operation
- States:
  - IDLE
  - BUSY (owner register = IF or D)
- Accept window:
  - The block accepts a request in IDLE.
  - It also accepts one in BUSY during the `m_ack` cycle, giving back-to-back issue.
- Selection when both request:
  - D wins.
  - In the fairness build, IF wins instead when `starve_cnt == STARVE_MAX`.
- On accept:
  - Assert the winner's `gnt` only.
  - Register `m_addr`, `m_wdata`, `m_write` (forced 0 for IF), and the owner.
  - Set `m_req=1` and enter BUSY.
- In BUSY, `m_req` and the `m_*` registers hold until `m_ack`.
- On `m_ack`:
  - Register `m_rdata` into the owner's `rdata` and pulse the owner's `rvalid`.
  - If a new request is accepted in the same cycle, stay in BUSY with the new owner.
  - Otherwise drop `m_req` and return to IDLE.
- `starve_cnt` (fairness build only):
  - Increments on each D grant while `if_req` is high.
  - Clears on an IF grant or whenever `if_req` is low.
  - Saturates at `STARVE_MAX`.
- Requests are ignored in BUSY outside the `m_ack` cycle; requesters keep `req` asserted.
- `m_ack` is ignored in IDLE. A simulation-only assertion flags it.
- Withdrawing `req` before `gnt` is legal; nothing is issued.

## Timing
- Reset (`rst_n` low at an edge):
  - State IDLE.
  - `m_req`, `m_write`, `if_rvalid`, `d_rvalid` = 0.
  - `m_addr`, `m_wdata`, `if_rdata`, `d_rdata` = 0.
  - `starve_cnt` = 0.
- `gnt` outputs are 0 while `rst_n` is low.
- Reset mid-transaction abandons it:
  - `m_req` falls the next cycle.
  - A later `m_ack` is ignored.
  - Memory must tolerate an abandoned request.
- Request at cycle t in IDLE:
  - `gnt` at t.
  - `m_req`, `m_addr` valid from t+1.
- Memory acks at cycle t+1+k (k ≥ 0):
  - Owner `rvalid` and `rdata` at t+2+k.
- Minimum latency from request to data is 2 cycles (`m_ack` in the first `m_req` cycle).
- Back-to-back throughput is one transaction per `m_ack`, with no idle cycle.

## Configuration
- `MEM_ARB_FAIRNESS_EN` defined:
  - `starve_cnt` and the IF override are compiled in.
  - Fetch waits at most `STARVE_MAX` data transactions.
- `MEM_ARB_FAIRNESS_EN` undefined:
  - Strict data priority; IF can starve under continuous data traffic.
  - `STARVE_MAX` is unused.

## Structure
- Shared package `mollusc_mem_pkg`:
  - State enum (IDLE, BUSY).
  - Owner enum (OWN_IF, OWN_D).
  - Default `STARVE_MAX` constant.
- Sub-module `mem_arb_pick`:
  - Combinational winner selection from `if_req`, `d_req`, `starve_cnt`, and the accept window.
  - Outputs `if_gnt` and `d_gnt`.
- Counter, FSM and registers live in `mem_arbiter`.

## Test plan
- Single load:
  - Stimulus: `d_req`, `d_addr=0x100`, `d_write=0` at t; `m_ack`, `m_rdata=0xDEADBEEF` at t+1.
  - Response: `d_gnt` at t; `m_req`, `m_addr=0x100` at t+1; `d_rvalid`, `d_rdata=0xDEADBEEF` at t+2.
- Simultaneous requests:
  - Stimulus: `if_req` (0x0) and `d_req` store (0x40, 0x12345678) at t.
  - Response: `d_gnt` at t with `m_write=1`, `m_wdata=0x12345678`; after that ack, `if_gnt` in the same ack cycle and `m_addr=0x0` the next cycle with `m_req` never dropping.
- Starvation, fairness build (`STARVE_MAX=4`):
  - Stimulus: `d_req` and `if_req` held continuously, `m_ack` every cycle.
  - Response: grants D, D, D, D, IF, D, ...
- Starvation, non-fairness build:
  - Stimulus: same as above.
  - Response: `if_gnt` never asserted.
- Reset mid-transaction:
  - Stimulus: `m_req` high, `rst_n` low for one cycle, then `m_ack`.
  - Response: `m_req` goes to 0; no `rvalid` pulse; state IDLE.
- Wait states:
  - Stimulus: `m_ack` delayed 5 cycles; `if_req` arrives during BUSY.
  - Response: `m_*` stable for 5 cycles; `if_gnt` only in the ack cycle.
